// File: rtl/saturation_pkg.sv
// Shared constants and helpers for the saturation filter: fixed latency,
// rounding constant and the final clamp used by each channel.
package saturation_pkg;

  localparam int unsigned LATENCY = 9;

  typedef struct packed {
    logic        clip;
    logic [63:0] val;
  } clamp_t;

  function automatic int unsigned round_adder(input int unsigned f);
    return (f == 0) ? 32'd0 : (32'd1 << (f - 1));
  endfunction

  function automatic clamp_t clamp_pix(input logic signed [63:0] v, input int unsigned pw);
    clamp_t            c;
    logic signed [63:0] vmax;
    vmax = (64'sd1 <<< pw) - 64'sd1;
    if (v < 64'sd0)
      c = '{clip: 1'b1, val: '0};
    else if (v > vmax)
      c = '{clip: 1'b1, val: $unsigned(vmax)};
    else
      c = '{clip: 1'b0, val: $unsigned(v)};
    return c;
  endfunction

endpackage

// File: rtl/saturation_ch.sv
// Per-channel back half of the saturation filter (stages 5-9):
// out = clamp(round(y*2^F + (pix - y)*sat)), or the raw pixel in bypass.
module saturation_ch
  import saturation_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH        = 8,
  parameter int unsigned COE_WIDTH          = 10,
  parameter int unsigned COE_FRACTION_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] pix,
  input  logic [PIXEL_WIDTH-1:0] y,
  input  logic [COE_WIDTH-1:0]   sat,
  input  logic                   bypass,
  output logic [PIXEL_WIDTH-1:0] out,
  output logic                   clip
);

  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned F  = COE_FRACTION_WIDTH;
  localparam int unsigned PC = PIXEL_WIDTH + COE_WIDTH;
  localparam int unsigned VW = PC + 2;
  localparam logic signed [VW-1:0] RND = VW'(round_adder(F));

  logic [PC-1:0]        pix_sat5, y_sat5, y_sat6;
  logic [PW-1:0]        y5, pix5, pix6, pix7, pix8;
  logic                 byp5, byp6, byp7, byp8;
  logic [PC:0]          s6;
  logic signed [VW-1:0] v7, r8;
  clamp_t               c;

  always_comb c = clamp_pix(64'(r8), PW);

  // The subtraction is split from the addition so each stage holds one adder;
  // the signed intermediate absorbs the (pix - y) negative range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_sat5 <= '0;
      y_sat5   <= '0;
      y5       <= '0;
      pix5     <= '0;
      byp5     <= '0;
      s6       <= '0;
      y_sat6   <= '0;
      pix6     <= '0;
      byp6     <= '0;
      v7       <= '0;
      pix7     <= '0;
      byp7     <= '0;
      r8       <= '0;
      pix8     <= '0;
      byp8     <= '0;
      out      <= '0;
      clip     <= '0;
    end else begin
      pix_sat5 <= PC'(pix) * PC'(sat);
      y_sat5   <= PC'(y) * PC'(sat);
      y5       <= y;
      pix5     <= pix;
      byp5     <= bypass;

      s6       <= (PC+1)'(pix_sat5) + ((PC+1)'(y5) << F);
      y_sat6   <= y_sat5;
      pix6     <= pix5;
      byp6     <= byp5;

      v7       <= $signed(VW'(s6)) - $signed(VW'(y_sat6));
      pix7     <= pix6;
      byp7     <= byp6;

      r8       <= (v7 + RND) >>> F;
      pix8     <= pix7;
      byp8     <= byp7;

      out      <= byp8 ? pix8 : c.val[PW-1:0];
      clip     <= byp8 ? 1'b0 : c.clip;
    end
  end

endmodule

// File: rtl/saturation_shadowed.sv
// RGB saturation filter with frame-synchronous shadow coefficients and a fixed
// 9-clock latency. Optional clip statistics: SATURATION_CLIP_STAT_EN.
module saturation_shadowed
  import saturation_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH        = 8,
  parameter int unsigned COE_WIDTH          = 10,
  parameter int unsigned COE_FRACTION_WIDTH = 6,
  parameter int unsigned SAT_DEFAULT        = 64,
  parameter int unsigned YCOE0_DEFAULT      = 19,
  parameter int unsigned YCOE1_DEFAULT      = 38,
  parameter int unsigned YCOE2_DEFAULT      = 7,
  parameter int unsigned CNT_WIDTH          = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COE_WIDTH-1:0]     saturation_i,
  input  logic [COE_WIDTH-1:0]     ycoe0_i,
  input  logic [COE_WIDTH-1:0]     ycoe1_i,
  input  logic [COE_WIDTH-1:0]     ycoe2_i,
  input  logic                     bypass_i,
  input  logic [3*PIXEL_WIDTH-1:0] di_i,
  input  logic                     de_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  output logic [3*PIXEL_WIDTH-1:0] do_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic [CNT_WIDTH-1:0]     clip_cnt_o
);

  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned CW = COE_WIDTH;
  localparam int unsigned F  = COE_FRACTION_WIDTH;
  localparam int unsigned PC = PIXEL_WIDTH + COE_WIDTH;
  localparam logic [PC+1:0] SRND = (PC+2)'(round_adder(F));
  localparam logic [PC+1:0] YMAX = (PC+2)'({PW{1'b1}});

  logic [CW-1:0] sat_a, ycoe0_a, ycoe1_a, ycoe2_a;
  logic          byp_a, vs_d;

  logic [PC-1:0]    p0_1, p1_1, p2_1, p2_2;
  logic [PC:0]      ps2;
  logic [PC+1:0]    s3, y_full;
  logic [PW-1:0]    y4;
  logic [3*PW-1:0]  pix1, pix2, pix3, pix4;
  logic [CW-1:0]    sat1, sat2, sat3, sat4;
  logic             byp1, byp2, byp3, byp4;
  logic [LATENCY-1:0] de_sr, hs_sr, vs_sr;
  logic [2:0]       clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_a   <= CW'(SAT_DEFAULT);
      ycoe0_a <= CW'(YCOE0_DEFAULT);
      ycoe1_a <= CW'(YCOE1_DEFAULT);
      ycoe2_a <= CW'(YCOE2_DEFAULT);
      byp_a   <= 1'b0;
      vs_d    <= 1'b0;
    end else begin
      vs_d <= vs_i;
      if (vs_i && !vs_d) begin
        sat_a   <= saturation_i;
        ycoe0_a <= ycoe0_i;
        ycoe1_a <= ycoe1_i;
        ycoe2_a <= ycoe2_i;
        byp_a   <= bypass_i;
      end
    end
  end

  always_comb y_full = (s3 + SRND) >> F;

  // sat and bypass travel with each pixel so a mid-pipeline swap never mixes frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_1 <= '0;
      p1_1 <= '0;
      p2_1 <= '0;
      ps2  <= '0;
      p2_2 <= '0;
      s3   <= '0;
      y4   <= '0;
      pix1 <= '0;
      pix2 <= '0;
      pix3 <= '0;
      pix4 <= '0;
      sat1 <= '0;
      sat2 <= '0;
      sat3 <= '0;
      sat4 <= '0;
      byp1 <= '0;
      byp2 <= '0;
      byp3 <= '0;
      byp4 <= '0;
    end else begin
      p0_1 <= PC'(ycoe0_a) * PC'(di_i[0 +: PW]);
      p1_1 <= PC'(ycoe1_a) * PC'(di_i[PW +: PW]);
      p2_1 <= PC'(ycoe2_a) * PC'(di_i[2*PW +: PW]);
      ps2  <= (PC+1)'(p0_1) + (PC+1)'(p1_1);
      p2_2 <= p2_1;
      s3   <= (PC+2)'(ps2) + (PC+2)'(p2_2);
      y4   <= (y_full > YMAX) ? YMAX[PW-1:0] : y_full[PW-1:0];
      pix1 <= di_i;
      pix2 <= pix1;
      pix3 <= pix2;
      pix4 <= pix3;
      sat1 <= sat_a;
      sat2 <= sat1;
      sat3 <= sat2;
      sat4 <= sat3;
      byp1 <= byp_a;
      byp2 <= byp1;
      byp3 <= byp2;
      byp4 <= byp3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= {de_sr[LATENCY-2:0], de_i};
      hs_sr <= {hs_sr[LATENCY-2:0], hs_i};
      vs_sr <= {vs_sr[LATENCY-2:0], vs_i};
    end
  end

  assign de_o = de_sr[LATENCY-1];
  assign hs_o = hs_sr[LATENCY-1];
  assign vs_o = vs_sr[LATENCY-1];

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    saturation_ch #(
      .PIXEL_WIDTH       (PIXEL_WIDTH),
      .COE_WIDTH         (COE_WIDTH),
      .COE_FRACTION_WIDTH(COE_FRACTION_WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .pix   (pix4[ch*PW +: PW]),
      .y     (y4),
      .sat   (sat4),
      .bypass(byp4),
      .out   (do_o[ch*PW +: PW]),
      .clip  (clip[ch])
    );
  end

`ifdef SATURATION_CLIP_STAT_EN
  logic                 vs_o_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           inc;
  logic [CNT_WIDTH:0]   sum;

  always_comb begin
    inc = de_o ? (2'(clip[0]) + 2'(clip[1]) + 2'(clip[2])) : 2'd0;
    sum = (CNT_WIDTH+1)'(cnt) + (CNT_WIDTH+1)'(inc);
  end

  // The increment seen on the vs_o edge belongs to the frame that starts there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_o_d     <= 1'b0;
      cnt        <= '0;
      clip_cnt_o <= '0;
    end else begin
      vs_o_d <= vs_o;
      if (vs_o && !vs_o_d) begin
        clip_cnt_o <= cnt;
        cnt        <= CNT_WIDTH'(inc);
      end else begin
        cnt <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      end
    end
  end
`else
  logic unused_clip;
  assign unused_clip = ^clip;
  assign clip_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_saturation_shadowed.sv
// Directed bench for saturation_shadowed: vector table plus shadow-timing,
// bypass, clip-statistics and mid-frame reset sequences.
module tb_saturation_shadowed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  saturation_i, ycoe0_i, ycoe1_i, ycoe2_i;
  logic        bypass_i;
  logic [23:0] di_i;
  logic        de_i, hs_i, vs_i;
  logic [23:0] do_o;
  logic        de_o, hs_o, vs_o;
  logic [23:0] clip_cnt_o;

  int tests = 0;
  int fails = 0;

  saturation_shadowed dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .saturation_i(saturation_i),
    .ycoe0_i     (ycoe0_i),
    .ycoe1_i     (ycoe1_i),
    .ycoe2_i     (ycoe2_i),
    .bypass_i    (bypass_i),
    .di_i        (di_i),
    .de_i        (de_i),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
    .do_o        (do_o),
    .de_o        (de_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .clip_cnt_o  (clip_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  sat, c0, c1, c2;
    logic        byp;
    logic [23:0] pix;
    logic [23:0] exp;
  } vec_t;

  function automatic logic [23:0] pk(input int r, input int g, input int b);
    return {8'(b), 8'(g), 8'(r)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_shadow(input logic [9:0] sat, input logic [9:0] c0, input logic [9:0] c1,
                             input logic [9:0] c2, input logic byp);
    @(posedge clk); #1;
    saturation_i = sat; ycoe0_i = c0; ycoe1_i = c1; ycoe2_i = c2; bypass_i = byp;
    vs_i = 1'b1;
    @(posedge clk); #1;
    vs_i = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_check(input string name, input logic [23:0] pix, input logic [23:0] exp);
    @(posedge clk); #1;
    di_i = pix; de_i = 1'b1; hs_i = 1'b1;
    @(posedge clk); #1;
    di_i = '0; de_i = 1'b0; hs_i = 1'b0;
    repeat (7) @(posedge clk);
    #1 check({name, "_de_early"}, 32'(de_o), 32'd0);
    @(posedge clk); #1;
    check({name, "_do"}, 32'(do_o), 32'(exp));
    check({name, "_de"}, 32'(de_o), 32'd1);
    check({name, "_hs"}, 32'(hs_o), 32'd1);
  endtask

  vec_t        vecs[9];
  logic [23:0] sexp[10];
  logic [23:0] bexp[21];

  initial begin
    vecs[0] = '{sat: 64,   c0: 19,   c1: 38,   c2: 7,    byp: 0, pix: pk(200,100,50), exp: pk(200,100,50)};
    vecs[1] = '{sat: 0,    c0: 19,   c1: 38,   c2: 7,    byp: 0, pix: pk(200,100,50), exp: pk(124,124,124)};
    vecs[2] = '{sat: 128,  c0: 19,   c1: 38,   c2: 7,    byp: 0, pix: pk(200,100,50), exp: pk(255,76,0)};
    vecs[3] = '{sat: 64,   c0: 19,   c1: 38,   c2: 7,    byp: 0, pix: pk(10,200,30),  exp: pk(10,200,30)};
    vecs[4] = '{sat: 128,  c0: 19,   c1: 38,   c2: 7,    byp: 0, pix: pk(124,124,124), exp: pk(124,124,124)};
    vecs[5] = '{sat: 0,    c0: 1023, c1: 1023, c2: 1023, byp: 0, pix: pk(10,20,30),   exp: pk(255,255,255)};
    vecs[6] = '{sat: 1023, c0: 19,   c1: 38,   c2: 7,    byp: 0, pix: pk(255,0,0),    exp: pk(255,0,0)};
    vecs[7] = '{sat: 32,   c0: 19,   c1: 38,   c2: 7,    byp: 0, pix: pk(100,150,200), exp: pk(121,146,171)};
    vecs[8] = '{sat: 0,    c0: 19,   c1: 38,   c2: 7,    byp: 1, pix: pk(12,34,56),   exp: pk(12,34,56)};

    rst_n = 1'b0;
    saturation_i = 10'd64; ycoe0_i = 10'd19; ycoe1_i = 10'd38; ycoe2_i = 10'd7; bypass_i = 1'b0;
    di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_do", 32'(do_o), 32'd0);
    check("reset_sync", {29'd0, de_o, hs_o, vs_o}, 32'd0);
    check("reset_clip_cnt", 32'(clip_cnt_o), 32'd0);
    rst_n = 1'b1;

    // Defaults active straight out of reset, no vs pulse needed.
    send_check("default_unity", pk(200,100,50), pk(200,100,50));

    for (int i = 0; i < 9; i++) begin
      load_shadow(vecs[i].sat, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].byp);
      send_check($sformatf("vec%0d", i), vecs[i].pix, vecs[i].exp);
    end

    // Shadow timing: saturation_i drops mid-frame, takes effect only after vs rise.
    load_shadow(10'd64, 10'd19, 10'd38, 10'd7, 1'b0);
    for (int i = 0; i < 10; i++) sexp[i] = (i <= 6) ? pk(200,100,50) : pk(124,124,124);
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      if (i >= 9) check($sformatf("shadow%0d", i - 9), 32'(do_o), 32'(sexp[i-9]));
      if (i < 10) begin
        di_i = pk(200,100,50); de_i = 1'b1;
        saturation_i = (i >= 2) ? 10'd0 : 10'd64;
        vs_i = (i == 6);
      end else begin
        de_i = 1'b0; vs_i = 1'b0; di_i = '0;
      end
    end

    // Bypass: random pixels pass through bit-exact with the same latency.
    load_shadow(10'd0, 10'd19, 10'd38, 10'd7, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i >= 9) check($sformatf("bypass%0d", i - 9), 32'(do_o), 32'(bexp[i-9]));
      if (i < 21) begin
        bexp[i] = 24'($urandom);
        di_i = bexp[i]; de_i = 1'b1;
      end else begin
        de_i = 1'b0; di_i = '0;
      end
    end

    // Clip statistics: 10 pixels with two clamped channels each.
    load_shadow(10'd128, 10'd19, 10'd38, 10'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      di_i = pk(200,100,50); de_i = 1'b1;
    end
    @(posedge clk); #1;
    de_i = 1'b0; di_i = '0;
    repeat (12) @(posedge clk);
    load_shadow(10'd128, 10'd19, 10'd38, 10'd7, 1'b0);
    #1;
`ifdef SATURATION_CLIP_STAT_EN
    check("clip_cnt_frame", 32'(clip_cnt_o), 32'd20);
`else
    check("clip_cnt_tied", 32'(clip_cnt_o), 32'd0);
`endif

    // Mid-frame reset flushes outputs and restores default coefficients.
    load_shadow(10'd0, 10'd1023, 10'd1023, 10'd1023, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      di_i = pk(10,20,30); de_i = 1'b1;
    end
    check("pre_reset_do", 32'(do_o), 32'(pk(255,255,255)));
    rst_n = 1'b0;
    #1;
    check("midreset_do", 32'(do_o), 32'd0);
    check("midreset_sync", {29'd0, de_o, hs_o, vs_o}, 32'd0);
    check("midreset_clip_cnt", 32'(clip_cnt_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    de_i = 1'b0; di_i = '0;
    rst_n = 1'b1;
    send_check("post_reset", pk(200,100,50), pk(200,100,50));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/saturation_shadowed.md
Name: saturation_shadowed

Overview:
Parametrised successor to the fixed 8-bit RGB saturation filter. Computes luma from R/G/B, then per channel out = y + (pix − y)·sat, rounded and clamped.
- All fixed-point widths are parameters.
- Coefficients are double-buffered and swapped only at frame start.
- Adds a bypass mode, reset defaults, and a fixed documented latency.
- Sits in the video filter chain between debayer/CCM and output formatting.

Parameters:
PIXEL_WIDTH, 8, bits per colour channel
COE_WIDTH, 10, unsigned coefficient width (integer + fraction bits)
COE_FRACTION_WIDTH, 6, fraction bits; 1.0 = 1<<COE_FRACTION_WIDTH
SAT_DEFAULT, 64, active saturation after reset
YCOE0_DEFAULT, 19, active R luma coefficient after reset
YCOE1_DEFAULT, 38, active G luma coefficient after reset
YCOE2_DEFAULT, 7, active B luma coefficient after reset
CNT_WIDTH, 24, clip counter width (optional feature only)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
saturation_i  in  COE_WIDTH  shadow saturation (Q, unsigned)
ycoe0_i  in  COE_WIDTH  shadow R luma coefficient
ycoe1_i  in  COE_WIDTH  shadow G luma coefficient
ycoe2_i  in  COE_WIDTH  shadow B luma coefficient
bypass_i  in  1  shadow bypass request
di_i  in  3*PIXEL_WIDTH  R [0 +: PW], G [PW +: PW], B [2PW +: PW]
de_i, hs_i, vs_i  in  1 each  video sync
do_o  out  3*PIXEL_WIDTH  processed pixel, same packing
de_o, hs_o, vs_o  out  1 each  sync delayed by LATENCY
clip_cnt_o  out  CNT_WIDTH  clipped-sample count of the previous frame (optional feature only)

Behaviour:
- Reset: asynchronous on rst_n low.
  - All pipeline registers, do_o, de_o, hs_o, vs_o and clip_cnt_o go to 0.
  - Active coefficients load the *_DEFAULT parameters; active bypass goes to 0.
  - Reset mid-frame flushes the pipeline; there is no partial-frame recovery and de_o stays 0 until new input propagates.
- Latency: LATENCY = 9 clocks, fixed and identical in bypass mode. Sync signals pass through a LATENCY-deep shift register.
- Shadow update:
  - vs_i rising edge = vs_i=1 with the registered vs_i = 0.
  - On that clock edge, active sat/ycoe*/bypass <= the *_i inputs.
  - The pixel presented on the edge cycle uses the old values; every later pixel uses the new ones.
  - Inputs changing at any other time have no effect.
- Luma:
  - S = ycoe0·R + ycoe1·G + ycoe2·B, computed at full precision (no truncation).
  - y = min(floor((S + 2^(F−1)) / 2^F), 2^PW − 1).
- Channel output:
  - v = y·2^F + (pix − y)·sat, as a signed intermediate wide enough for the worst case (PW + COE_WIDTH + 2 bits).
  - out = floor((v + 2^(F−1)) / 2^F), using an arithmetic shift.
  - Clamp: out < 0 → 0; out > 2^PW − 1 → all ones.
- Bypass active: do_o = di_i delayed by LATENCY, bit-exact.
- de_i=0 pixels are processed identically; no gating of the data path.
- Pipeline stages:
  1. products
  2. partial sum
  3. luma sum
  4. luma round/clip
  5. sat products
  6. add y·2^F
  7. subtract y·sat
  8. round
  9. clamp/register

Optional Feature:
Macro SATURATION_CLIP_STAT_EN.
- Defined:
  - An internal CNT_WIDTH counter adds the number (0..3) of channels clamped at stage 9 for each pixel with the delayed de = 1.
  - The counter saturates at all ones.
  - On a vs_o rising edge, clip_cnt_o <= counter and the counter clears; that cycle's increment is counted into the new frame.
  - Bypass frames count 0.
- Undefined: clip_cnt_o is tied to 0 and no counter logic exists.

Decomposition:
- Package saturation_pkg: LATENCY constant, ROUND_ADDER function of F, and a clamp/round helper function.
- One sub-module, saturation_ch: the per-channel stages 5–9, instantiated 3× with shared y and sat.
- Luma path and shadow registers stay in the top module.

Test Plan:
All cases use PW=8, F=6, COE_WIDTH=10, defaults 19/38/7 and sat 64.
- Unity: (200,100,50), sat=64 → (200,100,50) after exactly 9 clocks; de/hs/vs aligned.
- Greyscale: sat=0 loaded via vs pulse, pixel (200,100,50) → y = floor((7950+32)/64) = 124 → (124,124,124).
- Clamp both ends: sat=128, pixel (200,100,50) → (255,76,0). With SATURATION_CLIP_STAT_EN and a 10-pixel frame of this value, the next frame's clip_cnt_o = 20.
- Shadow timing: change saturation_i from 64 to 0 mid-frame → output unchanged until after the next vs_i rise; the pixel on the edge cycle uses 64.
- Bypass: bypass_i=1 latched at vs, random pixels → do_o equals di_i 9 clocks earlier, bit-exact.
- Reset mid-frame: assert rst_n low for 2 clocks during de → all outputs 0 immediately; active coefficients revert to 64/19/38/7, checked with pixel (200,100,50) → (200,100,50).
